// File: rtl/result_readout_pkg.sv
// Shared types and constants for the EPU result SRAM owner and host read-back path.
package result_readout_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EPU_W     = 2'd1,
        WRAPPER_R = 2'd2
    } readout_state_t;

    localparam int DEPTH_DEF = 2;

    localparam logic WRITE_ENB = 1'b1;
    localparam logic WRITE_DIS = 1'b0;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Small skid FIFO that absorbs the read data already in flight from the SRAM
// when the host stalls the output channel.
module result_skid_fifo
    import result_readout_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = 32,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage is only a couple of words, so it is reset along with the
    // pointers; that keeps rdata at zero out of reset instead of showing garbage.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/result_readout_wrapper.sv
// Owns the EPU result SRAM port: EPU writes while computing, then the host
// streams results out over a valid/ready channel with a 2-cycle read latency.
module result_readout_wrapper
    import result_readout_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enb_i,
    input  logic              epu_start_i,
    input  logic              epu_done_i,
    input  logic              rdfin_i,
    input  logic              epu_cs_i,
    input  logic              epu_oe_i,
    input  logic [ADDR_W-1:0] epu_addr_i,
    input  logic              epu_wreq_i,
    input  logic [DATA_W-1:0] epu_wdata_i,
    output logic [DATA_W-1:0] epu_rdata_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              rready_i,
    output logic              busy_o,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_wreq_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    localparam int CNT_W = cnt_width(DEPTH);

    readout_state_t   state_q;
    readout_state_t   state_d;
    logic             inflight_q;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (enb_i && epu_start_i) state_d = EPU_W;
            EPU_W:     if (epu_done_i)           state_d = WRAPPER_R;
            WRAPPER_R: if (enb_i && rdfin_i && !inflight_q && fifo_empty) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_cs_o    = 1'b0;
        sram_oe_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wreq_o  = WRITE_DIS;
        sram_wdata_o = '0;
        epu_rdata_o  = '0;
        busy_o       = (state_q != IDLE);
        unique case (state_q)
            EPU_W: begin
                sram_cs_o    = epu_cs_i;
                sram_oe_o    = epu_oe_i;
                sram_addr_o  = epu_addr_i;
                sram_wreq_o  = epu_wreq_i;
                sram_wdata_o = epu_wdata_i;
                epu_rdata_o  = sram_rdata_i;
            end
            WRAPPER_R: begin
                sram_cs_o   = rd_gnt_o;
                sram_oe_o   = rd_gnt_o;
                sram_addr_o = rd_addr_i;
            end
            default: ;
        endcase
    end

    // Grant only while the words already owed to the host still leave room in the FIFO.
    assign pop       = rvalid_o & rready_i;
    assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    always_comb begin
        rd_gnt_o = (state_q == WRAPPER_R) && enb_i && rd_req_i && !rdfin_i
                   && (occupancy < (CNT_W+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) inflight_q <= 1'b0;
        else       inflight_q <= rd_gnt_o;
    end

    result_skid_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_data (sram_rdata_i),
        .pop       (pop),
        .head      (rdata_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rvalid_o = ~fifo_empty;

    push_never_into_full: assert property (
        @(posedge clk) disable iff (!rstn) !(inflight_q && fifo_full && !pop)
    );

endmodule

// File: tb/tb_result_readout_wrapper.sv
// Directed bench for result_readout_wrapper with a behavioural 1-cycle SRAM model.
module tb_result_readout_wrapper;

    localparam int          ADDR_W = 14;
    localparam int          DATA_W = 32;
    localparam logic [31:0] BASE   = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              rstn;
    logic              enb_i, epu_start_i, epu_done_i, rdfin_i;
    logic              epu_cs_i, epu_oe_i, epu_wreq_i;
    logic [ADDR_W-1:0] epu_addr_i;
    logic [DATA_W-1:0] epu_wdata_i;
    logic [DATA_W-1:0] epu_rdata_o;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_gnt_o, rvalid_o, rready_i, busy_o;
    logic [DATA_W-1:0] rdata_o;
    logic              sram_cs_o, sram_oe_o, sram_wreq_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wdata_o;
    logic [DATA_W-1:0] sram_rdata_i;

    logic [DATA_W-1:0] sram_mem [256];

    int n_checks  = 0;
    int n_errors  = 0;
    int wreq_viol = 0;
    bit in_read   = 1'b0;

    always #5 clk = ~clk;

    result_readout_wrapper dut (
        .clk          (clk),
        .rstn         (rstn),
        .enb_i        (enb_i),
        .epu_start_i  (epu_start_i),
        .epu_done_i   (epu_done_i),
        .rdfin_i      (rdfin_i),
        .epu_cs_i     (epu_cs_i),
        .epu_oe_i     (epu_oe_i),
        .epu_addr_i   (epu_addr_i),
        .epu_wreq_i   (epu_wreq_i),
        .epu_wdata_i  (epu_wdata_i),
        .epu_rdata_o  (epu_rdata_o),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_gnt_o     (rd_gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rready_i     (rready_i),
        .busy_o       (busy_o),
        .sram_cs_o    (sram_cs_o),
        .sram_oe_o    (sram_oe_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wreq_o  (sram_wreq_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    // SRAM macro model: write on cs&wreq, read data appears the cycle after cs&oe.
    initial sram_rdata_i = '0;
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_wreq_o)    sram_mem[sram_addr_o[7:0]] <= sram_wdata_o;
            else if (sram_oe_o) sram_rdata_i <= sram_mem[sram_addr_o[7:0]];
        end
    end

    always @(negedge clk) if (in_read && sram_wreq_o) wreq_viol++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start, EPU writes BASE+i to 0..7, EPU reads one word back, then done.
    task automatic write_phase();
        int gnt_in_w = 0;
        enb_i = 1'b1; epu_start_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = '0;
        tick();
        epu_start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            epu_cs_i = 1'b1; epu_wreq_i = 1'b1; epu_oe_i = 1'b0;
            epu_addr_i = ADDR_W'(i); epu_wdata_i = BASE + i;
            @(negedge clk);
            if (rd_gnt_o) gnt_in_w++;
            if (i == 0) check("w_mux_wreq", sram_wreq_o, 1);
            tick();
        end
        check("w_no_gnt", gnt_in_w, 0);
        epu_wreq_i = 1'b0; epu_oe_i = 1'b1; epu_addr_i = 14'd5; rd_req_i = 1'b0;
        tick();
        epu_cs_i = 1'b0; epu_oe_i = 1'b0; epu_done_i = 1'b1;
        @(negedge clk);
        check("w_epu_rdata", epu_rdata_o, BASE + 5);
        tick();
        epu_done_i = 1'b0;
        @(negedge clk);
        check("w_busy_read", busy_o, 1);
        tick();
    endtask

    task automatic finish_read();
        int n = 0;
        rd_req_i = 1'b0; rready_i = 1'b1; rdfin_i = 1'b1;
        epu_cs_i = 1'b0; epu_wreq_i = 1'b0;
        @(negedge clk);
        while (busy_o && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("exit_idle", busy_o, 0);
        rdfin_i = 1'b0;
        in_read = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int next, got, first_gnt, first_val, last_val, stall, gnts, last_pop, idle_cyc;
        rstn = 1'b0;
        enb_i = 0; epu_start_i = 0; epu_done_i = 0; rdfin_i = 0;
        epu_cs_i = 0; epu_oe_i = 0; epu_wreq_i = 0; epu_addr_i = '0; epu_wdata_i = '0;
        rd_req_i = 0; rd_addr_i = '0; rready_i = 0;

        #12;
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_gnt_busy", {rd_gnt_o, busy_o}, 0);
        check("rst_sram", {sram_cs_o, sram_oe_o, sram_wreq_o}, 0);
        check("rst_sram_addr", sram_addr_o, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // epu_done outside EPU_W has no effect
        epu_done_i = 1'b1;
        tick();
        epu_done_i = 1'b0;
        @(negedge clk);
        check("done_in_idle", busy_o, 0);
        tick();

        // Full-rate read-back; start pulse and EPU write attempts during read are ignored
        write_phase();
        in_read = 1'b1;
        epu_cs_i = 1'b1; epu_wreq_i = 1'b1;
        next = 0; got = 0; first_gnt = -1; first_val = -1; last_val = -1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            rd_req_i = (next < 8); rd_addr_i = ADDR_W'(next); rready_i = 1'b1;
            epu_start_i = (cyc == 3);
            @(negedge clk);
            if (rvalid_o) begin
                check("t2_data", rdata_o, BASE + got);
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
                got++;
            end
            if (rd_gnt_o) begin
                if (first_gnt < 0) first_gnt = cyc;
                next++;
            end
            tick();
        end
        epu_start_i = 1'b0;
        check("t2_count", got, 8);
        check("t2_latency", first_val - first_gnt, 2);
        check("t2_rate", last_val - first_val, 7);
        finish_read();

        // Host stalls the first word for 5 cycles
        write_phase();
        in_read = 1'b1;
        next = 0; got = 0; stall = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            rd_req_i = (next < 8); rd_addr_i = ADDR_W'(next); rready_i = (stall >= 5);
            @(negedge clk);
            if (rvalid_o && !rready_i) begin
                check("t3_hold", rdata_o, BASE);
                check("t3_gnt_drop", rd_gnt_o, 0);
                stall++;
            end else if (rvalid_o) begin
                check("t3_data", rdata_o, BASE + got);
                got++;
            end
            if (rd_gnt_o) next++;
            tick();
        end
        check("t3_count", got, 8);
        check("t3_grants", next, 8);
        rd_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_no_dup", rvalid_o, 0);
            tick();
        end
        finish_read();

        // rdfin with two words pending: no grants, drain, then IDLE
        write_phase();
        in_read = 1'b1;
        next = 0;
        for (int c = 0; c < 3; c++) begin
            rd_req_i = 1'b1; rd_addr_i = ADDR_W'(next); rready_i = 1'b0;
            @(negedge clk);
            if (rd_gnt_o) next++;
            tick();
        end
        check("t4_pending", next, 2);
        rdfin_i = 1'b1; rready_i = 1'b1; rd_addr_i = ADDR_W'(next);
        got = 0; gnts = 0; last_pop = -1; idle_cyc = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (rd_gnt_o) gnts++;
            if (rvalid_o) begin
                check("t4_data", rdata_o, BASE + got);
                got++;
                last_pop = cyc;
            end
            if (!busy_o) begin
                idle_cyc = cyc;
                break;
            end
            tick();
        end
        check("t4_no_gnt", gnts, 0);
        check("t4_drained", got, 2);
        // FSM sees the FIFO empty the cycle after the last pop; state follows on that edge
        check("t4_idle_time", idle_cyc - last_pop, 2);
        rdfin_i = 1'b0; rd_req_i = 1'b0; in_read = 1'b0;
        tick();

        // Async reset with the FIFO full
        write_phase();
        in_read = 1'b1;
        next = 0;
        for (int c = 0; c < 4; c++) begin
            rd_req_i = 1'b1; rd_addr_i = ADDR_W'(next); rready_i = 1'b0;
            @(negedge clk);
            if (rd_gnt_o) next++;
            tick();
        end
        @(negedge clk);
        check("t1_pre_rvalid", rvalid_o, 1);
        #2 rstn = 1'b0;
        #1;
        check("t1_rvalid", rvalid_o, 0);
        check("t1_busy", busy_o, 0);
        check("t1_rdata", rdata_o, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check("t1_idle_busy", busy_o, 0);
        check("t1_idle_gnt", rd_gnt_o, 0);
        check("t1_idle_rvalid", rvalid_o, 0);
        rd_req_i = 1'b0; in_read = 1'b0;
        tick();

        check("t5_wreq_in_read", wreq_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
